nibble_serial_adder: RTL and testbench

- Parametrised successor to the team's combinational nibble adder.
- Adds or subtracts two WIDTH-bit operands serially, one NIB_W-bit nibble per clock, starting at the LSB nibble, with a registered carry.
- Also keeps the legacy single-nibble-pair add mode, selected by nibble index.
- Valid/ready handshake on input and output; sits between operand registers and a result consumer in the datapath.

---
 rtl/nibble_serial_adder_if.sv | 29 ++
 rtl/nibble_serial_adder.sv | 113 +++++++++++
 tb/tb_nibble_serial_adder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - operand/result handshake bundle for nibble_serial_adder
interface nibble_serial_adder_if #(
  parameter int WIDTH = 8,
  parameter int NIB_W = 4
);
  localparam int NUM_NIB = WIDTH / NIB_W;
  localparam int SEL_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic [SEL_W-1:0] sel;
  logic [WIDTH:0]   q;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output in_valid, a, b, op, sel, out_ready,
    input  in_ready, q, out_valid, busy
  );

  modport slave (
    input  in_valid, a, b, op, sel, out_ready,
    output in_ready, q, out_valid, busy
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - serial add/subtract, one nibble per clock, with single-nibble add mode
module nibble_serial_adder #(
  parameter int WIDTH = 8,
  parameter int NIB_W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int NUM_NIB = WIDTH / NIB_W;
  localparam int SEL_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [1:0]       op_r;
  logic [SEL_W-1:0] sel_r, cnt, idx;
  logic             carry, out_valid_r;
  logic [WIDTH:0]   q_r;
  logic             single, inv, last;
  logic [NIB_W-1:0] a_nib, b_nib;
  logic [NIB_W:0]   sum;

  assign single = (op_r == 2'b10);
  assign inv    = (op_r == 2'b01);
  assign last   = (cnt == LAST);

  // Single-nibble mode falls back to nibble 0 for an out-of-range index.
  always_comb begin
    idx = cnt;
    if (single) idx = (32'(sel_r) < NUM_NIB) ? sel_r : '0;
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NUM_NIB; i++) begin
      if (idx == SEL_W'(i)) begin
        a_nib = a_r[i*NIB_W +: NIB_W];
        b_nib = b_r[i*NIB_W +: NIB_W];
      end
    end
    if (single)
      sum = {1'b0, a_nib} + {1'b0, b_nib};
    else
      sum = {1'b0, a_nib} + {1'b0, b_nib ^ {NIB_W{inv}}} + {{NIB_W{1'b0}}, carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b1;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN:  if (single || last) state_nxt = DONE;
      DONE: if (out_valid_r && bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // out_valid is registered, so it rises one edge after DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= '0;
      b_r         <= '0;
      op_r        <= '0;
      sel_r       <= '0;
      cnt         <= '0;
      carry       <= 1'b0;
      q_r         <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_r   <= bus.a;
          b_r   <= bus.b;
          op_r  <= bus.op;
          sel_r <= bus.sel;
          q_r   <= '0;
          cnt   <= '0;
          carry <= (bus.op == 2'b01);
        end
        RUN: begin
          if (single) begin
            q_r <= (WIDTH+1)'(sum);
          end else begin
            for (int i = 0; i < NUM_NIB; i++)
              if (cnt == SEL_W'(i)) q_r[i*NIB_W +: NIB_W] <= sum[NIB_W-1:0];
            carry <= sum[NIB_W];
            cnt   <= cnt + 1'b1;
            if (last) q_r[WIDTH] <= sum[NIB_W];
          end
        end
        DONE: begin
          if (!out_valid_r)        out_valid_r <= 1'b1;
          else if (bus.out_ready)  out_valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.q         = q_r;
  assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - scoreboard bench for nibble_serial_adder (8- and 16-bit instances)
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(8),  .NIB_W(4)) bus8 ();
  nibble_serial_adder_if #(.WIDTH(16), .NIB_W(4)) bus16 ();

  nibble_serial_adder #(.WIDTH(8),  .NIB_W(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  nibble_serial_adder #(.WIDTH(16), .NIB_W(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [16:0] exp_q[$];
  int          exp_lat[$];
  int          acc_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [8:0] model8(input logic [1:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic sel);
    logic [3:0] an, bn;
    case (op)
      2'b01: return {1'b0, a} + {1'b0, ~b} + 9'd1;
      2'b10: begin
        an = sel ? a[7:4] : a[3:0];
        bn = sel ? b[7:4] : b[3:0];
        return {4'd0, {1'b0, an} + {1'b0, bn}};
      end
      default: return {1'b0, a} + {1'b0, b};
    endcase
  endfunction

  task automatic send8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic sel);
    int n = 0;
    while (!bus8.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("in_ready_before_accept", bus8.in_ready, 1);
    bus8.in_valid = 1'b1;
    bus8.op = op; bus8.a = a; bus8.b = b; bus8.sel = sel;
    @(posedge clk); #1;
    exp_q.push_back(17'(model8(op, a, b, sel)));
    exp_lat.push_back((op == 2'b10) ? 2 : 3);
    acc_cyc.push_back(cyc);
    bus8.in_valid = 1'b0;
    bus8.op = 2'($urandom); bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.sel = 1'($urandom);
    check("busy_after_accept", bus8.busy, 1);
    check("q_cleared_on_accept", bus8.q, 0);
  endtask

  // Waits for out_valid, scores it, optionally holds backpressure while pulsing in_valid, then handshakes.
  task automatic collect8(input string tag, input int hold);
    int n = 0;
    logic [16:0] e;
    while (!bus8.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_out_valid"}, bus8.out_valid, 1);
    check({tag, "_sb_has_entry"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_latency"}, cyc - acc_cyc.pop_front(), exp_lat.pop_front());
      check({tag, "_q"}, bus8.q, e);
      for (int i = 0; i < hold; i++) begin
        bus8.in_valid = 1'b1;
        bus8.op = 2'($urandom); bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        @(posedge clk); #1;
        check({tag, "_bp_q_stable"}, bus8.q, e);
        check({tag, "_bp_in_ready"}, bus8.in_ready, 0);
        check({tag, "_bp_out_valid"}, bus8.out_valid, 1);
      end
      bus8.in_valid = 1'b0;
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
      check({tag, "_out_valid_drop"}, bus8.out_valid, 0);
      check({tag, "_in_ready_idle"}, bus8.in_ready, 1);
      check({tag, "_q_retained"}, bus8.q, e);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    bus8.in_valid = 0; bus8.a = 0; bus8.b = 0; bus8.op = 0; bus8.sel = 0; bus8.out_ready = 0;
    bus16.in_valid = 0; bus16.a = 0; bus16.b = 0; bus16.op = 0; bus16.sel = 0; bus16.out_ready = 0;
    bus8.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", bus8.q, 0);
    check("reset_out_valid", bus8.out_valid, 0);
    check("reset_busy", bus8.busy, 0);
    check("reset_in_ready", bus8.in_ready, 1);
    bus8.in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    send8(2'b00, 8'h3C, 8'h4F, 1'b0); collect8("add_3c_4f", 0);
    send8(2'b00, 8'hFF, 8'h01, 1'b0); collect8("add_ff_01", 0);
    send8(2'b00, 8'h00, 8'h00, 1'b0); collect8("add_00_00", 0);
    send8(2'b01, 8'h50, 8'h23, 1'b0); collect8("sub_50_23", 0);
    send8(2'b01, 8'h23, 8'h50, 1'b0); collect8("sub_23_50", 0);
    send8(2'b01, 8'h77, 8'h77, 1'b0); collect8("sub_equal", 0);
    send8(2'b10, 8'hA3, 8'h9C, 1'b1); collect8("nib_sel1", 0);
    send8(2'b10, 8'hA3, 8'h9C, 1'b0); collect8("nib_sel0", 0);
    send8(2'b11, 8'h9A, 8'h77, 1'b1); collect8("op11_add", 0);

    send8(2'b00, 8'h12, 8'h34, 1'b0); collect8("backpressure", 5);
    send8(2'b00, 8'h11, 8'h22, 1'b0); collect8("after_bp", 0);
    n = 0;
    repeat (5) begin @(posedge clk); #1; if (bus8.out_valid) n++; end
    check("no_queued_result", n, 0);
    check("sb_drained", exp_q.size(), 0);

    for (int i = 0; i < 6; i++) begin
      send8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom));
      collect8("random", 0);
    end

    send8(2'b00, 8'hAA, 8'h55, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_q", bus8.q, 0);
    check("midrun_reset_out_valid", bus8.out_valid, 0);
    check("midrun_reset_busy", bus8.busy, 0);
    void'(exp_q.pop_back()); void'(exp_lat.pop_back()); void'(acc_cyc.pop_back());
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", bus8.in_ready, 1);
    n = 0;
    repeat (6) begin @(posedge clk); #1; if (bus8.out_valid) n++; end
    check("aborted_op_no_output", n, 0);

    bus16.in_valid = 1'b1; bus16.op = 2'b00; bus16.a = 16'hFFFF; bus16.b = 16'h0001;
    @(posedge clk); #1;
    exp_q.push_back(17'h10000);
    acc = cyc;
    bus16.in_valid = 1'b0; bus16.a = 16'h1234; bus16.b = 16'h4321;
    n = 0;
    while (!bus16.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("w16_out_valid", bus16.out_valid, 1);
    check("w16_latency", cyc - acc, 5);
    check("w16_q", bus16.q, exp_q.pop_front());
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    check("w16_out_valid_drop", bus16.out_valid, 0);
    check("w16_in_ready", bus16.in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
